// File: rtl/dmem_resp.sv
// Handshaked data-memory responder: wait states, byte-lane steering, load extension, errors.
// Optional: define DMEM_RESP_ERR_CNT_EN to add the saturating o_err_cnt error-response counter.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_w_data,
  input  logic [2:0]  i_fmt,
  input  logic        i_w_en,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_r_data,
  output logic        o_err
`ifdef DMEM_RESP_ERR_CNT_EN
  ,
  output logic [7:0]  o_err_cnt
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_fmt;
  logic        cap_wen;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   wr_word;
  logic [3:0]    be;
  logic [31:0]   ld;
  logic          fmt_bad;
  logic          misalign;
  logic          range_bad;
  logic          acc_err;
  logic          do_access;

  assign o_req_ready  = (state == ST_IDLE);
  assign o_resp_valid = (state == ST_RESP);
  assign idx          = cap_addr[AW+1:2];
  assign lane         = cap_addr[1:0];
  // The counter runs WAIT_CYCLES down to zero; the access happens in the zero cycle.
  assign do_access    = (state == ST_WAIT) && (cnt == 4'd0);

  always_comb begin
    rd_word   = mem[idx];
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = rd_word[{lane[1], 4'b0000} +: 16];
    wr_word   = cap_wdata << {lane, 3'b000};
    be        = 4'b0000;
    ld        = 32'd0;
    fmt_bad   = 1'b0;
    misalign  = 1'b0;
    case (cap_fmt)
      3'b000: begin
        be = 4'b0001 << lane;
        ld = {{24{rd_byte[7]}}, rd_byte};
      end
      3'b001: begin
        be       = 4'b0011 << lane;
        ld       = {{16{rd_half[15]}}, rd_half};
        misalign = cap_addr[0];
      end
      3'b010: begin
        be       = 4'b1111;
        ld       = rd_word;
        misalign = |cap_addr[1:0];
      end
      3'b100: begin
        be = 4'b0001 << lane;
        ld = {24'd0, rd_byte};
      end
      3'b101: begin
        be       = 4'b0011 << lane;
        ld       = {16'd0, rd_half};
        misalign = cap_addr[0];
      end
      default: fmt_bad = 1'b1;
    endcase
    range_bad = {2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS);
    // Unsigned formats have no store counterpart.
    acc_err   = fmt_bad | misalign | range_bad | (cap_wen & cap_fmt[2]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_fmt   <= 3'd0;
      cap_wen   <= 1'b0;
      o_r_data  <= 32'd0;
      o_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            cap_addr  <= i_addr;
            cap_wdata <= i_w_data;
            cap_fmt   <= i_fmt;
            cap_wen   <= i_w_en;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            o_err    <= acc_err;
            o_r_data <= (acc_err || cap_wen) ? 32'd0 : ld;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM is not reset; reset forces IDLE asynchronously so no write can follow it.
  always_ff @(posedge i_clk) begin
    if (do_access && !acc_err && cap_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_RESP_ERR_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_cnt <= 8'd0;
    end else if (o_resp_valid && i_resp_ready && o_err && (o_err_cnt != 8'hff)) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: byte-array reference model, random and directed traffic.
module tb_dmem_resp;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_w_data = 32'd0;
  logic [2:0]  i_fmt = 3'd0;
  logic        i_w_en = 1'b0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_r_data;
  logic        o_err;
`ifdef DMEM_RESP_ERR_CNT_EN
  logic [7:0]  o_err_cnt;
`endif

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_addr(i_addr),
    .i_w_data(i_w_data),
    .i_fmt(i_fmt),
    .i_w_en(i_w_en),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_r_data(o_r_data),
    .o_err(o_err)
`ifdef DMEM_RESP_ERR_CNT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_cnt = 0;
  bit rdy_force = 1'b0;
  bit rdy_val   = 1'b0;
  logic [32:0] sb_q [$];
  logic [7:0] mbytes [4*DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: memory as a flat little-endian byte array.
  function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                                input logic we, output logic e, output logic [31:0] d);
    int size;
    bit legal;
    logic [31:0] v;
    legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e = !legal || ((a % size) != 0) || ((a / 4) >= DEPTH) || (we && f >= 3'd4);
    d = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < size; i++) mbytes[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mbytes[int'(a) + i];
        if (f == 3'd0 && v[7])  v[31:8]  = 24'hffffff;
        if (f == 3'd1 && v[15]) v[31:16] = 16'hffff;
        d = v;
      end
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                       input logic we, input bit track);
    int t;
    logic e;
    logic [31:0] d;
    t = 0;
    @(negedge clk);
    while (!o_req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_req_ready) begin
      chk("req_ready_timeout", {31'd0, o_req_ready}, 32'd1);
      return;
    end
    i_addr = a; i_w_data = wd; i_fmt = f; i_w_en = we; i_req_valid = 1'b1;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    if (track) begin
      model(a, wd, f, we, e, d);
      sb_q.push_back({e, d});
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || o_resp_valid || !o_req_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sb_q.size(), 32'd0);
  endtask

  // Monitor: drives response backpressure and checks each accepted response.
  always @(negedge clk) begin
    logic [32:0] ex;
    i_resp_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    if (!i_rst && o_resp_valid && i_resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        ex = sb_q.pop_front();
        chk("resp_err", {31'd0, o_err}, {31'd0, ex[32]});
        chk("resp_data", o_r_data, ex[31:0]);
        if (ex[32] && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] hold;
    logic [31:0] ra;
    foreach (mbytes[i]) mbytes[i] = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_r_data", o_r_data, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
`ifdef DMEM_RESP_ERR_CNT_EN
    chk("rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);
`endif
    @(negedge clk);
    i_rst = 1'b0;

    for (int w = 0; w < DEPTH; w++) issue(32'(4 * w), 32'd0, 3'b010, 1'b1, 1'b1);
    drain();

    // Store then load, with request-to-response latency measurement.
    issue(32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 1'b1);
    n = 0;
    while (!o_resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(WAITC + 1));
    issue(32'h10, 32'd0, 3'b010, 1'b0, 1'b1);

    issue(32'h10, 32'h11223344, 3'b010, 1'b1, 1'b1);
    issue(32'h13, 32'h00000080, 3'b000, 1'b1, 1'b1);
    issue(32'h10, 32'd0, 3'b010, 1'b0, 1'b1);
    issue(32'h13, 32'd0, 3'b000, 1'b0, 1'b1);
    issue(32'h13, 32'd0, 3'b100, 1'b0, 1'b1);
    issue(32'h12, 32'd0, 3'b001, 1'b0, 1'b1);
    issue(32'h12, 32'd0, 3'b010, 1'b0, 1'b1);
    issue(32'h11, 32'h0000AAAA, 3'b001, 1'b1, 1'b1);
    issue(32'h10, 32'd0, 3'b010, 1'b0, 1'b1);
    issue(32'(4 * DEPTH), 32'd0, 3'b010, 1'b0, 1'b1);
    drain();

    // Backpressure: response held for five cycles.
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    issue(32'h10, 32'd0, 3'b010, 1'b0, 1'b1);
    n = 0;
    while (!o_resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    hold = o_r_data;
    chk("bp_data_value", hold, 32'h80223344);
    repeat (5) begin
      @(posedge clk);
      #2;
      chk("bp_valid", {31'd0, o_resp_valid}, 32'd1);
      chk("bp_data_stable", o_r_data, hold);
      chk("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    rdy_val = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("bp_release_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("bp_release_idle", {31'd0, o_req_ready}, 32'd1);
    rdy_force = 1'b0;
    drain();

    // Asynchronous reset during WAIT drops the store.
    issue(32'h20, 32'h12345678, 3'b010, 1'b1, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("arst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("arst_r_data", o_r_data, 32'd0);
    chk("arst_err", {31'd0, o_err}, 32'd0);
    @(negedge clk);
    exp_cnt = 0;
    i_rst = 1'b0;
    issue(32'h20, 32'd0, 3'b010, 1'b0, 1'b1);
    drain();

    issue(32'h20, 32'd0, 3'b011, 1'b0, 1'b1);
    drain();
`ifdef DMEM_RESP_ERR_CNT_EN
    chk("err_cnt_first", {24'd0, o_err_cnt}, 32'(exp_cnt));
`endif
    issue(32'h20, 32'h55, 3'b100, 1'b1, 1'b1);
    drain();
`ifdef DMEM_RESP_ERR_CNT_EN
    chk("err_cnt_second", {24'd0, o_err_cnt}, 32'(exp_cnt));
`endif

    for (int k = 0; k < 400; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 64))
                                       : 32'($urandom_range(0, 4 * DEPTH - 1));
      issue(ra, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
`ifdef DMEM_RESP_ERR_CNT_EN
    chk("err_cnt_final", {24'd0, o_err_cnt}, 32'(exp_cnt));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
